// File: rtl/edge_map_writer.sv
// Thresholds a raster gradient stream into a binary edge map,
// then streams the finished map out as packed bytes.
module edge_map_writer #(
  parameter int MAP_W  = 2,
  parameter int MAP_H  = 2,
  parameter int GRAD_W = 11,
  localparam int NPIX   = MAP_W * MAP_H,
  localparam int NBYTES = (NPIX + 7) / 8,
  localparam int CW     = $clog2(NPIX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GRAD_W-1:0] gradient,
  input  logic              gradient_valid,
  input  logic [GRAD_W-1:0] threshold,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              frame_done,
  output logic [CW-1:0]     edge_count,
  output logic              overflow
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IW = KW + 3;

  localparam logic CAPTURE = 1'b0;
  localparam logic READOUT = 1'b1;

  localparam logic [IW-1:0] LAST_PIX  = IW'(NPIX - 1);
  localparam logic [KW-1:0] LAST_BYTE = KW'(NBYTES - 1);

  logic                     state;
  logic [IW-1:0]            pix;
  logic [KW-1:0]            k;
  logic [NBYTES-1:0][7:0]   map;
  logic [GRAD_W-1:0]        thr_q;
  logic [CW-1:0]            run;
  logic [GRAD_W-1:0]        thr_use;
  logic                     hit;

  // pixel 0 sees the live threshold; the rest of the frame reuses it
  assign thr_use = (pix == '0) ? threshold : thr_q;
  assign hit     = gradient >= thr_use;

  assign rd_valid = (state == READOUT);
  assign rd_last  = rd_valid && (k == LAST_BYTE);
  assign rd_data  = rd_valid ? map[k] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CAPTURE;
      pix        <= '0;
      k          <= '0;
      map        <= '0;
      thr_q      <= '0;
      run        <= '0;
      edge_count <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        CAPTURE: begin
          if (gradient_valid) begin
            map[pix[IW-1:3]][pix[2:0]] <= hit;
            if (pix == '0)
              thr_q <= threshold;
            if (pix == LAST_PIX) begin
              edge_count <= run + CW'(hit);
              run        <= '0;
              frame_done <= 1'b1;
              state      <= READOUT;
            end else begin
              pix <= pix + IW'(1);
              run <= run + CW'(hit);
            end
          end
        end
        READOUT: begin
          if (gradient_valid)
            overflow <= 1'b1;
          if (rd_ready) begin
            if (k == LAST_BYTE) begin
              k     <= '0;
              map   <= '0;
              pix   <= '0;
              state <= CAPTURE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: doc/edge_map_writer.md
Name: edge_map_writer

Overview:
- Sink for the gradient stream produced by the Sobel stage: receives `gradient`/`gradient_valid` in raster order.
- Thresholds each gradient into a 1-bit edge decision and stores a full binary edge map for one frame.
- Once the frame is complete, streams the map out as packed bytes over a valid/ready readout interface, for the downstream host/UART/memory writer.

Parameters:
- MAP_W, 2, valid gradient columns per row (image width minus 2).
- MAP_H, 2, valid gradient rows per frame (image height minus 2).
- GRAD_W, 11, gradient width (max magnitude 2040).
- Derived: NPIX = MAP_W*MAP_H; NBYTES = ceil(NPIX/8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- gradient  in  GRAD_W  unsigned gradient magnitude.
- gradient_valid  in  1  gradient qualifier, one pixel per asserted cycle, no backpressure.
- threshold  in  GRAD_W  edge threshold, latched per frame.
- rd_data  out  8  packed edge bits.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  downstream accepts rd_data.
- rd_last  out  1  marks final byte of frame.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is captured.
- edge_count  out  clog2(NPIX+1)  edges in the last completed frame.
- overflow  out  1  sticky: gradient arrived while not capturing.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; state CAPTURE; pixel index, byte index and edge map cleared; latched threshold 0. Reset mid-frame or mid-readout aborts the frame; no partial output.
- States: CAPTURE, READOUT.
- CAPTURE, on each gradient_valid:
  - edge = (gradient >= thr), unsigned compare.
  - thr = live `threshold` for pixel index 0, and that value is latched. Pixels 1..NPIX-1 use the latched value, so mid-frame threshold changes are ignored.
  - Store edge at bit index pix = row*MAP_W + col (raster order), increment pix, accumulate the running edge total.
  - Gaps in gradient_valid are allowed; the index advances only on valid cycles.
- Last pixel (pix == NPIX-1 accepted):
  - frame_done=1 for exactly that following cycle.
  - edge_count updated (including the last pixel) in the same cycle; held until the next frame_done.
  - State goes to READOUT; rd_valid=1 in that same cycle with byte 0.
- READOUT:
  - Byte k = map bits 8k..8k+7, bit 0 = lowest pixel index. Bits beyond NPIX-1 read 0.
  - rd_valid held high; rd_data and rd_last stable while rd_ready=0.
  - Handshake when rd_valid && rd_ready: advance k.
  - rd_last=1 exactly when k == NBYTES-1.
  - Handshake on the last byte: next cycle rd_valid=0, rd_last=0, map and pix cleared, state CAPTURE. Back-to-back frames need only that one-cycle turnaround.
- Overflow: gradient_valid while in READOUT drops the sample (no map, count or index change) and sets overflow=1. overflow clears only on reset.
- Widths: edge_count cannot overflow (sized for NPIX). gradient is never negative; no sign handling.
- Latency: last pixel valid -> frame_done and first rd_valid 1 cycle later. Each byte then takes 1 cycle with rd_ready held high.

Test Plan:
- MAP_W=2, MAP_H=2, threshold=100, gradients 50,100,2040,99 on consecutive cycles -> edges 0,1,1,0; frame_done single pulse 1 cycle after 99; rd_data=0x06 with rd_valid=1, rd_last=1; edge_count=2.
- MAP_W=4, MAP_H=4, threshold=10, gradients alternating 0/20 (16 px, with idle gaps), rd_ready low for 3 cycles then high -> rd_data held at 0xAA through stall; bytes 0xAA, 0xAA; rd_last only on second byte; edge_count=8.
- Threshold=100 at pixel 0, changed to 0 at pixel 1, gradients all 50 (2x2) -> rd_data=0x00, edge_count=0.
- Gradient_valid pulsed during READOUT (2x2 frame) -> overflow=1 and stays 1; next frame's map and edge_count are unaffected by the dropped sample.
- rst_n low for 1 cycle mid-readout (rd_ready=0) -> next cycle all outputs 0, state CAPTURE; a fresh 2x2 frame of all 2040 with threshold 1 yields 0x0F, edge_count=4.
- Two frames back-to-back with the minimum 1-cycle turnaround after final handshake -> two correct frame_done pulses and two correct byte sequences, overflow=0.
